// File: rtl/spi_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_slave
// Description : SPI slave frame engine for the user-area SPI port. Decodes
//               frames of {R/W flag, address, data}, MSB first. Writes are
//               presented as a parallel word; reads shift the selected user
//               word out on MISO. Runs purely in the BCLK domain; SS high is
//               the asynchronous reset of the whole block.
// Ports       : i_BCLK       - master SPI clock (rising edge active)
//               i_SS         - slave select, low while framing; high = reset
//               i_MOSI       - serial data from master
//               o_MISO       - serial data to master (registered)
//               o_RW         - frame flag, 0 = write, 1 = read
//               o_ADDR       - received address
//               o_ADDR_VALID - address complete (sticky until reset)
//               o_DATA_IN    - write word (updated once, on the last bit)
//               o_DOUT_VALID - write word complete (sticky until reset)
//               i_DATA_OUT   - read word from the addressed user module
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_slave #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     i_BCLK,
    input  logic                     i_SS,
    input  logic                     i_MOSI,
    output logic                     o_MISO,
    output logic                     o_RW,
    output logic [ADDRESS_WIDTH-1:0] o_ADDR,
    output logic                     o_ADDR_VALID,
    output logic [DATA_WIDTH-1:0]    o_DATA_IN,
    output logic                     o_DOUT_VALID,
    input  logic [DATA_WIDTH-1:0]    i_DATA_OUT
);

    localparam logic [5:0] ADDR_LAST = 6'(ADDRESS_WIDTH - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [5:0]              bit_cnt;
    // Write shadow holds all but the final bit; o_DATA_IN is loaded in one
    // shot so downstream never sees partially shifted words.
    logic [DATA_WIDTH-2:0]   wr_shadow;
    // Remaining read bits after the MSB has been driven out.
    logic [DATA_WIDTH-2:0]   tx_shift;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_BCLK or posedge i_SS) begin
        if (i_SS) begin
            state <= S_CMD;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_CMD:   next_state = S_ADDR;
            S_ADDR:  if (bit_cnt == ADDR_LAST) next_state = o_RW ? S_RDATA : S_WDATA;
            S_WDATA: if (bit_cnt == DATA_LAST) next_state = S_DONE;
            S_RDATA: if (bit_cnt == DATA_LAST) next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            default: next_state = S_CMD;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, shift registers and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_BCLK or posedge i_SS) begin
        if (i_SS) begin
            bit_cnt      <= '0;
            wr_shadow    <= '0;
            tx_shift     <= '0;
            o_MISO       <= 1'b0;
            o_RW         <= 1'b0;
            o_ADDR       <= '0;
            o_ADDR_VALID <= 1'b0;
            o_DATA_IN    <= '0;
            o_DOUT_VALID <= 1'b0;
        end else begin
            case (state)
                S_CMD: begin
                    o_RW    <= i_MOSI;
                    bit_cnt <= '0;
                end
                S_ADDR: begin
                    o_ADDR <= {o_ADDR[ADDRESS_WIDTH-2:0], i_MOSI};
                    if (bit_cnt == ADDR_LAST) begin
                        o_ADDR_VALID <= 1'b1;
                        bit_cnt      <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_WDATA: begin
                    wr_shadow <= {wr_shadow[DATA_WIDTH-3:0], i_MOSI};
                    if (bit_cnt == DATA_LAST) begin
                        o_DATA_IN    <= {wr_shadow, i_MOSI};
                        o_DOUT_VALID <= 1'b1;
                        bit_cnt      <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_RDATA: begin
                    // The user word is captured only on the first data edge;
                    // later changes on i_DATA_OUT cannot affect this frame.
                    if (bit_cnt == 6'd0) begin
                        o_MISO   <= i_DATA_OUT[DATA_WIDTH-1];
                        tx_shift <= i_DATA_OUT[DATA_WIDTH-2:0];
                    end else begin
                        o_MISO   <= tx_shift[DATA_WIDTH-2];
                        tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
                    end
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: begin
                    // DONE: ignore further clocks, hold everything.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_slave
// Description : Self-checking bench for spi_frame_slave. A frame-level model
//               derives every output from the rising-edge count and the bits
//               received so far; a single compare process checks the DUT
//               shortly after each falling BCLK edge and each SS rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_slave;

    logic        bclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        rw;
    logic [6:0]  addr;
    logic        addr_valid;
    logic [31:0] data_in;
    logic        dout_valid;
    logic [31:0] data_out;

    int n_vec = 0;
    int n_err = 0;

    spi_frame_slave #(.ADDRESS_WIDTH(7), .DATA_WIDTH(32)) dut (
        .i_BCLK       (bclk),
        .i_SS         (ss),
        .i_MOSI       (mosi),
        .o_MISO       (miso),
        .o_RW         (rw),
        .o_ADDR       (addr),
        .o_ADDR_VALID (addr_valid),
        .o_DATA_IN    (data_in),
        .o_DOUT_VALID (dout_valid),
        .i_DATA_OUT   (data_out)
    );

    // ------------------------------------------------------------------
    // Frame model: edge count, received bits, read word seen at edge 9
    // ------------------------------------------------------------------
    int          m_edges = 0;
    logic        m_bits [0:39];
    logic [31:0] m_rd = '0;

    always @(posedge bclk or posedge ss) begin
        if (ss) begin
            m_edges = 0;
        end else begin
            m_edges = m_edges + 1;
            if (m_edges <= 40) m_bits[m_edges-1] = mosi;
            if (m_edges == 9) m_rd = data_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t, edges=%0d)",
                     name, act, exp, $time, m_edges);
        end
    endtask

    // Single compare process, sampling away from the active edge.
    always begin
        logic        e_rw, e_av, e_dv, e_miso;
        logic [6:0]  e_addr;
        logic [31:0] e_data;
        int          e, k;
        @(negedge bclk or posedge ss);
        #1;
        e      = m_edges;
        e_rw   = (e >= 1) ? m_bits[0] : 1'b0;
        e_addr = '0;
        for (int i = 1; i <= 7; i++) if (i < e) e_addr = {e_addr[5:0], m_bits[i]};
        e_av   = (e >= 8);
        e_dv   = !e_rw && (e >= 40);
        e_data = '0;
        if (e_dv) for (int i = 8; i < 40; i++) e_data = {e_data[30:0], m_bits[i]};
        e_miso = 1'b0;
        if (e_rw && e >= 9) begin
            k      = (e > 40) ? 40 : e;
            e_miso = m_rd[31-(k-9)];
        end
        check("rw",         {31'd0, rw},         {31'd0, e_rw});
        check("addr",       {25'd0, addr},       {25'd0, e_addr});
        check("addr_valid", {31'd0, addr_valid}, {31'd0, e_av});
        check("dout_valid", {31'd0, dout_valid}, {31'd0, e_dv});
        check("data_in",    data_in,             e_data);
        check("miso",       {31'd0, miso},       {31'd0, e_miso});
    end

    // ------------------------------------------------------------------
    // Master driver
    // ------------------------------------------------------------------
    task automatic pulse(input logic b);
        mosi = b;
        #10 bclk = 1'b1;
        #10 bclk = 1'b0;
    endtask

    // Runs n_edges rising edges of a frame (fewer than 40 = abort, more = extra
    // clocks with random MOSI). late_dout replaces i_DATA_OUT after edge 9.
    task automatic frame(input logic f_rw, input logic [6:0] f_addr,
                         input logic [31:0] f_data, input int n_edges,
                         input bit change_late, input logic [31:0] late_dout,
                         output logic [31:0] rx);
        logic [39:0] bits;
        bits = {f_rw, f_addr, f_data};
        rx   = '0;
        #5 ss = 1'b0;
        #10;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 9 && f_rw) #150;
            pulse((k <= 40) ? bits[40-k] : 1'($urandom));
            if (k >= 9 && k <= 40) begin
                #1 rx = {rx[30:0], miso};
            end
            if (k == 9 && change_late) data_out = late_dout;
        end
        #20;
    endtask

    task automatic end_frame();
        ss = 1'b1;
        #20;
    endtask

    initial begin
        logic [31:0] rx;
        logic        r_rw;
        logic [6:0]  r_addr;
        logic [31:0] r_data;
        int          n;
        bclk = 1'b0; ss = 1'b0; mosi = 1'b0; data_out = '0;
        #1 ss = 1'b1;
        #20;
        check("reset_data_in",    data_in, 32'h0);
        check("reset_dout_valid", {31'd0, dout_valid}, 32'h0);

        // Write 0xF0F0F0F0 to address 0x00
        frame(1'b0, 7'h00, 32'hF0F0F0F0, 40, 1'b0, '0, rx);
        check("wr1_data_in",    data_in, 32'hF0F0F0F0);
        check("wr1_dout_valid", {31'd0, dout_valid}, 32'h1);
        end_frame();
        check("wr1_cleared", {rw, addr, addr_valid, dout_valid, miso} == '0 ? 32'h0 : 32'h1, 32'h0);

        // Read of 0xDEADBEEF from address 0x02
        data_out = 32'hDEADBEEF;
        frame(1'b1, 7'h02, 32'h0, 40, 1'b0, '0, rx);
        check("rd1_addr", {25'd0, addr}, 32'h2);
        check("rd1_word", rx, 32'hDEADBEEF);
        end_frame();

        // Read word must be frozen at edge 9
        data_out = 32'hF0F0F0F0;
        frame(1'b1, 7'h00, 32'h0, 40, 1'b1, 32'h12345678, rx);
        check("rd2_frozen", rx, 32'hF0F0F0F0);
        end_frame();

        // Abort a write after 20 edges, then a clean write
        frame(1'b0, 7'h11, 32'hCAFEBABE, 20, 1'b0, '0, rx);
        end_frame();
        check("abort_dout_valid", {31'd0, dout_valid}, 32'h0);
        frame(1'b0, 7'h7F, 32'hA5A5A5A5, 40, 1'b0, '0, rx);
        check("after_abort_addr", {25'd0, addr}, 32'h7F);
        check("after_abort_data", data_in, 32'hA5A5A5A5);
        end_frame();

        // Extra clocks after a write must not disturb anything
        frame(1'b0, 7'h33, 32'h0000FFFF, 50, 1'b0, '0, rx);
        check("extra_data_in",    data_in, 32'h0000FFFF);
        check("extra_dout_valid", {31'd0, dout_valid}, 32'h1);
        end_frame();

        // Clocks while deselected do nothing
        for (int k = 0; k < 50; k++) pulse(1'($urandom));
        check("ss_high_data_in", data_in, 32'h0);
        check("ss_high_addr_valid", {31'd0, addr_valid}, 32'h0);

        // Randomized frames: reads, writes, aborts, extra clocks
        for (int t = 0; t < 40; t++) begin
            r_rw     = 1'($urandom);
            r_addr   = 7'($urandom);
            r_data   = $urandom;
            data_out = $urandom;
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, 39);
                1:       n = 40 + $urandom_range(1, 8);
                default: n = 40;
            endcase
            frame(r_rw, r_addr, r_data, n, 1'($urandom), $urandom, rx);
            end_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
